// File: rtl/inst_rom_ctl_pkg.sv
// Shared constants for the instruction ROM loader: bus widths, the
// reset/enable levels, the NOP word and the loader FSM encodings.
// Build option: INST_ROM_ALIGN_CHK_EN (enables misaligned-fetch detection).
package inst_rom_ctl_pkg;

   // Bus widths shared with the core
   localparam int RegBusW      = 32;
   localparam int InstAddrBusW = 32;

   // Signal levels
   localparam logic RstEnable  = 1'b1;
   localparam logic ChipEnable = 1'b1;

   // Returned whenever a fetch is not served; executes as a NOP
   localparam logic [RegBusW-1:0] ZeroWord = 32'h0000_0000;

   // Loader FSM encodings
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; the controller hides stale
// words by gating reads with the loaded-word count.
module inst_rom_mem
   import inst_rom_ctl_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [RegBusW-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [RegBusW-1:0] rdata
);

   logic [RegBusW-1:0] mem [0:(2**AW)-1];

   // Write port: one word per accepted load transfer
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Asynchronous read so the core sees the word in the same cycle
   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_ctl.sv
// Instruction ROM controller: accepts an image over a valid/ready load
// stream, then serves combinational instruction fetches to the core.
// Build option: INST_ROM_ALIGN_CHK_EN -- when defined, fetches with
// addr[1:0] != 0 raise misalign_o and return ZeroWord; when undefined,
// misalign_o is tied low and addr[1:0] is ignored.
module inst_rom_ctl
   import inst_rom_ctl_pkg::*;
#(
   parameter int ROM_AW = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic [InstAddrBusW-1:0] addr,
   output logic [RegBusW-1:0]      inst,
   input  logic                    ld_valid,
   input  logic [RegBusW-1:0]      ld_data,
   input  logic                    ld_last,
   input  logic                    ld_clr,
   output logic                    ld_ready,
   output logic                    busy,
   output logic [ROM_AW:0]         ld_count,
   output logic                    misalign_o
);

   localparam logic [ROM_AW:0] DEPTH    = (ROM_AW+1)'(2**ROM_AW);
   localparam logic [ROM_AW:0] LAST_IDX = DEPTH - 1'b1;

   logic [1:0]         state;
   logic               xfer;
   logic               fill_done;
   logic [ROM_AW-1:0]  rd_idx;
   logic [RegBusW-1:0] rd_data;
   logic               rd_hit;
   logic               misalign;

   // Handshake: ready until the image is complete; a clear kills any
   // transfer offered in the same cycle so nothing is written.
   assign ld_ready  = (state != ST_READY);
   assign busy      = (state != ST_READY);
   assign xfer      = ld_valid & ld_ready & ~ld_clr & (rst != RstEnable);
   assign fill_done = ld_last | (ld_count == LAST_IDX);

   // Loader FSM and word counter; clear has priority over loading
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state    <= ST_EMPTY;
         ld_count <= '0;
      end else if (ld_clr) begin
         state    <= ST_EMPTY;
         ld_count <= '0;
      end else if (xfer) begin
         if (ld_count != DEPTH) ld_count <= ld_count + 1'b1;
         state <= fill_done ? ST_READY : ST_LOAD;
      end
   end

   // Word index from the byte address; upper address bits are ignored
   assign rd_idx = addr[ROM_AW+1:2];

   inst_rom_mem #(.AW(ROM_AW)) u_mem (
      .clk   (clk),
      .we    (xfer),
      .waddr (ld_count[ROM_AW-1:0]),
      .wdata (ld_data),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   // Serve only words that belong to the current, complete image
   assign rd_hit = (ce == ChipEnable) && (state == ST_READY) &&
                   ({1'b0, rd_idx} < ld_count);

`ifdef INST_ROM_ALIGN_CHK_EN
   assign misalign = (ce == ChipEnable) && (state == ST_READY) &&
                     (addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign misalign_o = misalign;
   assign inst       = (rd_hit && !misalign) ? rd_data : ZeroWord;

   // Address bits that never select a word
   logic unused_addr;
   assign unused_addr = ^{addr[InstAddrBusW-1:ROM_AW+2], addr[1:0]};

endmodule
